wb_stage_arb: RTL
=================

Name: wb_stage_arb

Overview:
- Parametrised writeback stage for the core's register-file write path.
- Selects the in-order pipeline result by wb_sel: ALU, LSU, PC+4 or CSR.
- Also accepts out-of-order results from long-latency units (divider, AMO) through a valid/ready port backed by a DEPTH-entry FIFO.
- Arbitrates both onto NUM_WR_PORTS register-file write ports, prevents FIFO starvation, and reports pending destination registers to hazard logic.

Parameters:
XLEN, 32, datapath width
DEPTH, 4, late-result FIFO entries (power of 2, >=2)
NUM_WR_PORTS, 1, register-file write ports (1 or 2)
STARVE_MAX, 8, cycles a non-empty FIFO may wait before stall_req asserts (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  pipeline writeback slot valid
in_opr_res  in  XLEN  ALU result
in_lsu_rdata  in  XLEN  load data
in_pc4  in  XLEN  PC+4
in_csr_rdata  in  XLEN  CSR read data
in_rd  in  5  destination register
in_rf_en  in  1  write enable
in_wb_sel  in  2  0=ALU, 1=LSU, 2=PC4, 3=CSR
late_valid  in  1  late result valid
late_ready  out  1  FIFO can accept
late_data  in  XLEN  late result
late_rd  in  5  late destination
stall_req  out  1  pipeline must present a bubble (in_valid=0) this cycle
query_rd  in  5  hazard query register
query_hit  out  1  query_rd has a pending late write
rf_wr_en  out  NUM_WR_PORTS  per-port write enable
rf_wr_rd  out  5*NUM_WR_PORTS  per-port rd, port p at [5p+4:5p]
rf_wr_data  out  XLEN*NUM_WR_PORTS  per-port data

Behaviour:
- Reset (async, rst=1): all rf_wr_* outputs, stall_req, FIFO pointers, count and starvation counter go to 0. late_ready=0 while rst is high, then 1 (FIFO empty). In-flight FIFO contents are discarded.
- Main path: sampled at edge t when in_valid & in_rf_en & in_rd!=0. Port 0 drives the write during cycle t+1 with the wb_sel-muxed data. Otherwise rf_wr_en[0]=0. Writes to x0 are never issued.
- Late port: handshake completes when late_valid & late_ready. late_ready = !full; there is no pass-through when full. Entries with late_rd=0 are accepted and dropped.
- Drain, NUM_WR_PORTS=2: the head pops every cycle the FIFO is non-empty and is written on port 1 the following cycle.
- Drain, NUM_WR_PORTS=1: the head pops at an edge only when no main write is captured at that edge. The popped head occupies port 0 the next cycle.
- Collision, both configurations: if the popped head rd equals the main rd captured at the same edge, the main write wins. The late entry is discarded, since the main instruction is younger. Hazard logic normally prevents this; the defined behaviour still holds.
- Starvation counter: increments each cycle the FIFO is non-empty and no pop occurs. Clears on a pop or when the FIFO is empty. Saturates at STARVE_MAX.
- stall_req: registered, equal to (counter==STARVE_MAX). While stall_req=1, upstream holds in_valid=0, guaranteeing a pop. stall_req drops the cycle after the pop. It is never asserted when NUM_WR_PORTS=2.
- Simultaneous enqueue and dequeue: count unchanged. Pointers wrap modulo DEPTH.
- query_hit: combinational. Set if any valid FIFO entry, or a late write currently on an rf_wr port, has rd==query_rd and query_rd!=0.
- Ordering: FIFO drain order equals acceptance order.

Test Plan:
- Main mux: in_valid=1, rf_en=1, rd=5, wb_sel=0..3 with operands 0x11, 0x22, 0x33, 0x44 -> next cycle rf_wr_en[0]=1, rd=5, data equals the matching operand. A rd=0 case gives no write.
- Late enqueue/drain, 1 port, idle pipeline: late (rd=7, 0xDEAD) -> query_hit=1 for query_rd=7 until the write. Port 0 writes x7=0xDEAD two cycles after the handshake; query_hit then 0.
- Starvation, STARVE_MAX=8, 1 port: continuous main writes plus one late entry -> stall_req=1 after 8 stalled cycles. Bench drops in_valid -> late write issues, stall_req=0 the next cycle.
- Full/backpressure, DEPTH=4, busy pipeline: 4 late accepts -> late_ready=0. A fifth late_valid is held and not lost. Order of the 4 writes is preserved.
- 2 ports with collision: main rd=3 (0xA) and popped head rd=3 (0xB) at the same edge -> only port 0 writes x3=0xA. Same scenario with rd 3 vs 4 writes both ports in one cycle.
- Reset mid-operation: assert rst with 3 entries queued and stall_req=1 -> immediately all outputs 0 and query_hit=0. After release late_ready=1 and no stale writes appear.

Source files
------------

// File: rtl/wb_stage_arb.sv
// Register-file writeback stage: muxes the in-order pipeline result and drains
// a FIFO of out-of-order late results onto NUM_WR_PORTS write ports.
module wb_stage_arb #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int NUM_WR_PORTS = 1,
  parameter int STARVE_MAX   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [XLEN-1:0]              in_opr_res,
  input  logic [XLEN-1:0]              in_lsu_rdata,
  input  logic [XLEN-1:0]              in_pc4,
  input  logic [XLEN-1:0]              in_csr_rdata,
  input  logic [4:0]                   in_rd,
  input  logic                         in_rf_en,
  input  logic [1:0]                   in_wb_sel,
  input  logic                         late_valid,
  output logic                         late_ready,
  input  logic [XLEN-1:0]              late_data,
  input  logic [4:0]                   late_rd,
  output logic                         stall_req,
  input  logic [4:0]                   query_rd,
  output logic                         query_hit,
  output logic [NUM_WR_PORTS-1:0]      rf_wr_en,
  output logic [5*NUM_WR_PORTS-1:0]    rf_wr_rd,
  output logic [XLEN*NUM_WR_PORTS-1:0] rf_wr_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] SMAX     = SW'(STARVE_MAX);
  localparam bit DUAL = (NUM_WR_PORTS == 2);
  localparam int LP   = NUM_WR_PORTS - 1;

  logic [XLEN-1:0] mem_data [DEPTH];
  logic [4:0]      mem_rd   [DEPTH];
  logic [AW-1:0]   qoff     [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;
  logic [SW-1:0]   starve, starve_nxt;
  logic            full, empty, push, pop, main_cap, collide, late_wr, late_out;
  logic [XLEN-1:0] main_data;
  logic            p_en   [NUM_WR_PORTS];
  logic [4:0]      p_rd   [NUM_WR_PORTS];
  logic [XLEN-1:0] p_data [NUM_WR_PORTS];

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign late_ready = !rst && !full;
  // x0 late results complete the handshake but never occupy a slot
  assign push       = late_valid && late_ready && (late_rd != '0);
  assign main_cap   = in_valid && in_rf_en && (in_rd != '0);
  assign pop        = !empty && (DUAL || !main_cap);
  // the younger in-order write to the same rd supersedes the late one
  assign collide    = pop && main_cap && (mem_rd[rptr] == in_rd);
  assign late_wr    = pop && !collide;

  always_comb begin
    main_data = in_opr_res;
    case (in_wb_sel)
      2'd1:    main_data = in_lsu_rdata;
      2'd2:    main_data = in_pc4;
      2'd3:    main_data = in_csr_rdata;
      default: main_data = in_opr_res;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wptr] <= late_data;
      mem_rd[wptr]   <= late_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_comb begin
    starve_nxt = starve;
    if (empty || pop)          starve_nxt = '0;
    else if (starve != SMAX)   starve_nxt = starve + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve    <= '0;
      stall_req <= 1'b0;
    end else begin
      starve    <= starve_nxt;
      stall_req <= !DUAL && (starve_nxt == SMAX);
    end
  end

  // port 0 carries the main write; the late write goes on the last port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      late_out <= 1'b0;
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        p_en[p]   <= 1'b0;
        p_rd[p]   <= '0;
        p_data[p] <= '0;
      end
    end else begin
      late_out <= late_wr;
      p_en[0]  <= main_cap || (!DUAL && late_wr);
      if (main_cap) begin
        p_rd[0]   <= in_rd;
        p_data[0] <= main_data;
      end else if (!DUAL && late_wr) begin
        p_rd[0]   <= mem_rd[rptr];
        p_data[0] <= mem_data[rptr];
      end
      if (DUAL) begin
        p_en[LP] <= late_wr;
        if (late_wr) begin
          p_rd[LP]   <= mem_rd[rptr];
          p_data[LP] <= mem_data[rptr];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_WR_PORTS; p++) begin : g_port
    assign rf_wr_en[p]                 = p_en[p];
    assign rf_wr_rd[5*p +: 5]          = p_rd[p];
    assign rf_wr_data[XLEN*p +: XLEN]  = p_data[p];
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) qoff[i] = AW'(i) - rptr;
  end

  always_comb begin
    query_hit = late_out && (p_rd[LP] == query_rd);
    for (int i = 0; i < DEPTH; i++)
      if (({1'b0, qoff[i]} < count) && (mem_rd[i] == query_rd)) query_hit = 1'b1;
    if (query_rd == '0) query_hit = 1'b0;
  end
endmodule
